// File: rtl/hazard_scheduler_pkg.sv
// Shared encodings and helpers for the pipeline hazard scheduler:
// Tuse/Tnew codes, forward-source selects and mult/div latency defaults.
package hazard_scheduler_pkg;

  localparam logic [1:0] TUSE_ID   = 2'd0;
  localparam logic [1:0] TUSE_EX   = 2'd1;
  localparam logic [1:0] TUSE_MEM  = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W        = 4;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } shadow_t;

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    logic [1:0] r;
    if (v == TNEW_LINK) r = TNEW_LINK;
    else                r = v - 2'd1;
    return r;
  endfunction

  // A producer blocks the operand while its result is further away than the consumer's need.
  function automatic logic operand_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                          input shadow_t ex, input shadow_t mem);
    logic hz;
    if (src != 5'd0 && tuse != TUSE_NONE)
      hz = ((ex.dst == src) && (ex.tnew > tuse)) || ((mem.dst == src) && (mem.tnew > tuse));
    else
      hz = 1'b0;
    return hz;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input shadow_t mem,
                                         input logic [4:0] wb_dst);
    logic [1:0] sel;
    if (src == 5'd0)                                  sel = FWD_RF;
    else if (mem.dst == src && mem.tnew == TNEW_LINK) sel = FWD_EXMEM;
    else if (wb_dst == src)                           sel = FWD_MEMWB;
    else                                              sel = FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scheduler_md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit; loads its latency when
// an MD instruction sits in EX and counts down to idle.
module md_busy_counter
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load on launch, else count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                       cnt_d = is_div_i ? DIV_LOAD : MULT_LOAD;
    else if (cnt_q != {MD_CNT_W{1'b0}}) cnt_d = cnt_q - {{(MD_CNT_W-1){1'b0}}, 1'b1};
    else                              cnt_d = cnt_q;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= {MD_CNT_W{1'b0}};
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != {MD_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/flush/forward controller: shadow scoreboard of EX/MEM/WB destinations
// and Tnew, checked against the Tuse of the instruction in ID, plus mult/div gating.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_tuse_rs,
  input  logic [1:0] id_tuse_rt,
  input  logic [4:0] id_dst,
  input  logic [1:0] id_tnew,
  input  logic       id_md_start,
  input  logic       id_md_is_div,
  input  logic       id_md_access,
  output logic       stall_front,
  output logic       clr_id_ex,
  output logic [1:0] fwd_rs_id,
  output logic [1:0] fwd_rt_id,
  output logic       md_start_ex,
  output logic       md_busy
);

  shadow_t    ex_q, ex_d, mem_q, mem_d;
  logic [4:0] wb_dst_q, wb_dst_d;
  logic       ex_md_q, ex_md_d, ex_is_div_q, ex_is_div_d;

  logic hz_rs_s, hz_rt_s, hz_md_s, stall_s, md_busy_s;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ex_md_q),
    .is_div_i(ex_is_div_q),
    .busy_o  (md_busy_s)
  );

  assign hz_rs_s = operand_hazard(id_rs, id_tuse_rs, ex_q, mem_q);
  assign hz_rt_s = operand_hazard(id_rt, id_tuse_rt, ex_q, mem_q);
  // An MD instruction still in EX has not loaded the counter yet, so it blocks too.
  assign hz_md_s = id_md_access & (md_busy_s | ex_md_q);
  assign stall_s = hz_rs_s | hz_rt_s | hz_md_s;

  assign stall_front = stall_s;
  assign clr_id_ex   = stall_s;
  assign fwd_rs_id   = fwd_sel(id_rs, mem_q, wb_dst_q);
  assign fwd_rt_id   = fwd_sel(id_rt, mem_q, wb_dst_q);
  assign md_start_ex = ex_md_q;
  assign md_busy     = md_busy_s;

  // Shadow next state: a stalled ID enters EX as a bubble.
  always_comb begin
    ex_d        = '0;
    ex_md_d     = 1'b0;
    ex_is_div_d = 1'b0;
    if (!stall_s) begin
      ex_d.dst    = id_dst;
      ex_d.tnew   = id_tnew;
      ex_md_d     = id_md_start;
      ex_is_div_d = id_md_start & id_md_is_div;
    end else begin
      ex_d        = '0;
      ex_md_d     = 1'b0;
      ex_is_div_d = 1'b0;
    end
    mem_d.dst  = ex_q.dst;
    mem_d.tnew = sat_dec(ex_q.tnew);
    wb_dst_d   = mem_q.dst;
  end

  // Shadow scoreboard registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_dst_q    <= 5'd0;
      ex_md_q     <= 1'b0;
      ex_is_div_q <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_dst_q    <= wb_dst_d;
      ex_md_q     <= ex_md_d;
      ex_is_div_q <= ex_is_div_d;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed pipeline scenarios then random
// instruction streams, checked against an age-based reference model.
module tb_hazard_scheduler;
  import hazard_scheduler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
  logic       id_md_start, id_md_is_div, id_md_access;
  logic       stall_front, clr_id_ex, md_start_ex, md_busy;
  logic [1:0] fwd_rs_id, fwd_rt_id;

  hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
    .id_dst(id_dst), .id_tnew(id_tnew),
    .id_md_start(id_md_start), .id_md_is_div(id_md_is_div), .id_md_access(id_md_access),
    .stall_front(stall_front), .clr_id_ex(clr_id_ex),
    .fwd_rs_id(fwd_rs_id), .fwd_rt_id(fwd_rt_id),
    .md_start_ex(md_start_ex), .md_busy(md_busy)
  );

  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       md, div, acc;
  } instr_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] frs, frt;
    logic       mds, busy;
  } exp_t;

  // In-flight producers by age since entering EX: 0 = EX, 1 = MEM, 2 = WB.
  typedef struct { int dst; int tnew; bit md; bit div; } slot_t;
  slot_t slot [3];
  int    cyc, md_end;

  exp_t  expq [$];
  int    n_cmp = 0, n_bad = 0;
  logic  obs_stall;

  function automatic void chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endfunction

  function automatic int remain(int tnew, int age);
    return (tnew > age) ? tnew - age : 0;
  endfunction

  function automatic bit model_hz(int s, int u);
    if (s == 0 || u == 3) return 1'b0;
    for (int a = 0; a < 2; a++)
      if (slot[a].dst == s && remain(slot[a].tnew, a) > u) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_fwd(int s);
    if (s == 0) return 0;
    if (slot[1].dst == s && remain(slot[1].tnew, 1) == 0) return 1;
    if (slot[2].dst == s) return 2;
    return 0;
  endfunction

  function automatic exp_t model_eval(instr_t i);
    exp_t e;
    bit   busy;
    busy    = (cyc < md_end);
    e.mds   = slot[0].md;
    e.busy  = busy;
    e.stall = model_hz(int'(i.rs), int'(i.tu_rs)) | model_hz(int'(i.rt), int'(i.tu_rt)) |
              (i.acc & (busy | slot[0].md));
    e.frs   = 2'(model_fwd(int'(i.rs)));
    e.frt   = 2'(model_fwd(int'(i.rt)));
    return e;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 3; a++) slot[a] = '{0, 0, 1'b0, 1'b0};
    md_end = 0;
  endtask

  task automatic model_step(instr_t i, bit stall, bit rst);
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      if (slot[0].md) md_end = cyc + (slot[0].div ? 10 : 5);
      slot[2] = slot[1];
      slot[1] = slot[0];
      if (stall) slot[0] = '{0, 0, 1'b0, 1'b0};
      else       slot[0] = '{int'(i.dst), int'(i.tnew), i.md, i.md & i.div};
    end
  endtask

  task automatic drive(instr_t i);
    id_rs = i.rs; id_rt = i.rt; id_tuse_rs = i.tu_rs; id_tuse_rt = i.tu_rt;
    id_dst = i.dst; id_tnew = i.tnew;
    id_md_start = i.md; id_md_is_div = i.div; id_md_access = i.acc;
  endtask

  task automatic one_cycle(instr_t i, bit rst, output bit st);
    exp_t e;
    drive(i);
    reset = rst;
    e = model_eval(i);
    expq.push_back(e);
    st = e.stall;
    @(negedge clk);
    obs_stall = stall_front;
    @(posedge clk);
    model_step(i, e.stall, rst);
    #1;
    reset = 1'b0;
  endtask

  task automatic issue(instr_t i, output int held);
    bit st;
    held = 0;
    for (int k = 0; k < 30; k++) begin
      one_cycle(i, 1'b0, st);
      if (obs_stall) held++;
      if (!st) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL issue_timeout: instruction still stalled after 30 cycles");
  endtask

  function automatic instr_t mk(int rs, int rt, logic [1:0] tr, logic [1:0] tt, int dst,
                                logic [1:0] tn, bit md, bit dv, bit acc);
    instr_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.tu_rs = tr; i.tu_rt = tt;
    i.dst = 5'(dst); i.tnew = tn; i.md = md; i.div = dv; i.acc = acc;
    return i;
  endfunction

  // Monitor: outputs are valid every cycle; compare against the queued expectation.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("stall_front", int'(stall_front), int'(e.stall));
      chk("clr_id_ex",   int'(clr_id_ex),   int'(e.stall));
      chk("fwd_rs_id",   int'(fwd_rs_id),   int'(e.frs));
      chk("fwd_rt_id",   int'(fwd_rt_id),   int'(e.frt));
      chk("md_start_ex", int'(md_start_ex), int'(e.mds));
      chk("md_busy",     int'(md_busy),     int'(e.busy));
    end
  end

  instr_t nop, lw1, add2, add1, beq1, lw0, use0, divi, mult, mflo, lw4, add4, add5, ri;
  int     h;
  bit     st;

  task automatic drain();
    for (int k = 0; k < 12; k++) issue(nop, h);
  endtask

  initial begin
    nop  = mk(0, 0, TUSE_NONE, TUSE_NONE, 0, TNEW_LINK, 0, 0, 0);
    lw1  = mk(2, 0, TUSE_EX,  TUSE_NONE, 1, TNEW_LOAD, 0, 0, 0);
    add2 = mk(1, 3, TUSE_EX,  TUSE_EX,   2, TNEW_ALU,  0, 0, 0);
    add1 = mk(2, 3, TUSE_EX,  TUSE_EX,   1, TNEW_ALU,  0, 0, 0);
    beq1 = mk(1, 0, TUSE_ID,  TUSE_ID,   0, TNEW_LINK, 0, 0, 0);
    lw0  = mk(2, 0, TUSE_EX,  TUSE_NONE, 0, TNEW_LOAD, 0, 0, 0);
    use0 = mk(0, 0, TUSE_ID,  TUSE_MEM,  6, TNEW_ALU,  0, 0, 0);
    divi = mk(2, 3, TUSE_EX,  TUSE_EX,   0, TNEW_LINK, 1, 1, 1);
    mult = mk(2, 3, TUSE_EX,  TUSE_EX,   0, TNEW_LINK, 1, 0, 1);
    mflo = mk(0, 0, TUSE_NONE, TUSE_NONE, 7, TNEW_ALU, 0, 0, 1);
    lw4  = mk(2, 0, TUSE_EX,  TUSE_NONE, 4, TNEW_LOAD, 0, 0, 0);
    add4 = mk(2, 3, TUSE_EX,  TUSE_EX,   4, TNEW_ALU,  0, 0, 0);
    add5 = mk(4, 0, TUSE_ID,  TUSE_NONE, 5, TNEW_ALU,  0, 0, 0);

    cyc = 0;
    model_clear();
    drive(nop);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    issue(nop, h);                                   // reset state, all outputs 0
    issue(lw1, h);  issue(add2, h); chk("held_load_use", h, 1);
    drain();
    issue(add1, h); issue(beq1, h); chk("held_alu_branch", h, 1);
    drain();
    issue(lw1, h);  issue(beq1, h); chk("held_load_branch", h, 2);
    drain();
    issue(lw0, h);  issue(use0, h); chk("held_zero_reg", h, 0);
    drain();
    issue(divi, h); issue(mflo, h); chk("held_div_mflo", h, 11);
    drain();
    issue(mult, h); issue(mflo, h); chk("held_mult_mflo", h, 6);
    drain();
    issue(divi, h); issue(divi, h); chk("held_div_div", h, 11);
    drain();
    issue(divi, h);
    repeat (4) issue(nop, h);
    one_cycle(mflo, 1'b1, st);                       // reset mid-division
    issue(mflo, h); chk("held_after_reset", h, 0);
    drain();
    issue(lw4, h); issue(add4, h); issue(add5, h); chk("held_young_wins", h, 1);
    drain();

    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      ri = mk(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 2'($urandom_range(0, 2)), 0, 0, 0);
      if (r < 6) begin
        ri.md = 1'b1; ri.div = 1'($urandom_range(0, 1)); ri.acc = 1'b1; ri.dst = 5'd0;
      end else begin
        ri.acc = (r < 12);
      end
      if (r >= 98) one_cycle(ri, 1'b1, st);
      else         issue(ri, h);
    end

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
